dnn_aggr_ctrl: RTL

- Sequencer and aggregator on the consumer side of the two dnn node instances, n0 and n1.
- Sequences dnn_state through layer-1 and final-output phases.
- Each layer-1 cycle, samples the ReLU outputs of both nodes and accumulates them over N_VEC input vectors into saturating 15-bit sums.
- Feeds those sums back as y*_n*_aggr, captures the final out0/out1 results, and presents them downstream on a valid/ready handshake.

---
 rtl/dnn_aggr_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/dnn_aggr_ctrl.sv
// Consumer-side sequencer for the n0/n1 dnn nodes: walks the layer-1 and final-output
// phases, accumulates saturating ReLU sums and hands the final results downstream.
package dnn_aggr_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAYER1    = 2'd1,
    FINAL_OUT = 2'd2,
    DONE      = 2'd3
  } dnn_state_t;
endpackage

module dnn_aggr_ctrl
  import dnn_aggr_pkg::*;
#(
  parameter int N_VEC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_ready,
  input  logic [12:0]        y4_relu_n0,
  input  logic [12:0]        y5_relu_n0,
  input  logic [12:0]        y6_relu_n0,
  input  logic [12:0]        y7_relu_n0,
  input  logic [12:0]        y4_relu_n1,
  input  logic [12:0]        y5_relu_n1,
  input  logic [12:0]        y6_relu_n1,
  input  logic [12:0]        y7_relu_n1,
  input  logic signed [20:0] out0_n0,
  input  logic signed [20:0] out1_n0,
  input  logic signed [20:0] out0_n1,
  input  logic signed [20:0] out1_n1,
  input  logic               out0_n0_ready,
  input  logic               out1_n0_ready,
  output dnn_state_t         dnn_state,
  output logic signed [14:0] y4_n0_aggr,
  output logic signed [14:0] y5_n0_aggr,
  output logic signed [14:0] y6_n0_aggr,
  output logic signed [14:0] y7_n0_aggr,
  output logic signed [14:0] y4_n1_aggr,
  output logic signed [14:0] y5_n1_aggr,
  output logic signed [14:0] y6_n1_aggr,
  output logic signed [14:0] y7_n1_aggr,
  output logic signed [20:0] res0_n0,
  output logic signed [20:0] res1_n0,
  output logic signed [20:0] res0_n1,
  output logic signed [20:0] res1_n1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_L1   = 3'd1,
    S_FIN  = 3'd2,
    S_CAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [14:0] SAT_MAX = 15'h3FFF;

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_cnt;
  logic               r_vld_d1;
  logic [14:0]        r_acc [8];
  logic signed [20:0] r_res0_n0;
  logic signed [20:0] r_res1_n0;
  logic signed [20:0] r_res0_n1;
  logic signed [20:0] r_res1_n1;
  logic [11:0]        w_relu [8];
  logic               w_last;
  logic               w_cap;
  logic               w_unused;

  // Bit 12 of each ReLU input is never driven high by a node, so only 12 bits are summed.
  assign w_relu[0] = y4_relu_n0[11:0];
  assign w_relu[1] = y5_relu_n0[11:0];
  assign w_relu[2] = y6_relu_n0[11:0];
  assign w_relu[3] = y7_relu_n0[11:0];
  assign w_relu[4] = y4_relu_n1[11:0];
  assign w_relu[5] = y5_relu_n1[11:0];
  assign w_relu[6] = y6_relu_n1[11:0];
  assign w_relu[7] = y7_relu_n1[11:0];
  assign w_unused  = ^{y4_relu_n0[12], y5_relu_n0[12], y6_relu_n0[12], y7_relu_n0[12],
                       y4_relu_n1[12], y5_relu_n1[12], y6_relu_n1[12], y7_relu_n1[12]};

  assign w_last = (r_cnt == 8'(N_VEC - 1));
  assign w_cap  = out0_n0_ready & out1_n0_ready;

  function automatic logic [14:0] satAdd(input logic [14:0] a, input logic [11:0] b);
    logic [15:0] s;
    s = {1'b0, a} + {4'b0, b};
    return (s > {1'b0, SAT_MAX}) ? SAT_MAX : s[14:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_L1;
      S_L1:    if (r_vld_d1 && w_last) w_next = S_FIN;
      S_FIN:   w_next = S_CAP;
      S_CAP:   if (w_cap) w_next = S_DONE;
      S_DONE:  if (res_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    dnn_state = IDLE;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      S_IDLE:  busy = 1'b0;
      S_L1:    dnn_state = LAYER1;
      S_FIN:   dnn_state = FINAL_OUT;
      S_CAP:   dnn_state = FINAL_OUT;
      S_DONE: begin
        dnn_state = DONE;
        res_valid = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // The node registers its ReLU one cycle after x, so the sample is taken on the delayed strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_vld_d1  <= 1'b0;
      r_res0_n0 <= '0;
      r_res1_n0 <= '0;
      r_res0_n1 <= '0;
      r_res1_n1 <= '0;
      for (int i = 0; i < 8; i++) r_acc[i] <= '0;
    end else begin
      r_vld_d1 <= (r_state == S_L1) && in_ready && !(r_vld_d1 && w_last);
      if (r_state == S_IDLE && start) begin
        r_cnt     <= '0;
        r_res0_n0 <= '0;
        r_res1_n0 <= '0;
        r_res0_n1 <= '0;
        r_res1_n1 <= '0;
        for (int i = 0; i < 8; i++) r_acc[i] <= '0;
      end else if (r_state == S_L1 && r_vld_d1) begin
        r_cnt <= r_cnt + 8'd1;
        for (int i = 0; i < 8; i++) r_acc[i] <= satAdd(r_acc[i], w_relu[i]);
      end
      if (r_state == S_CAP && w_cap) begin
        r_res0_n0 <= out0_n0;
        r_res1_n0 <= out1_n0;
        r_res0_n1 <= out0_n1;
        r_res1_n1 <= out1_n1;
      end
    end
  end

  assign y4_n0_aggr = $signed(r_acc[0]);
  assign y5_n0_aggr = $signed(r_acc[1]);
  assign y6_n0_aggr = $signed(r_acc[2]);
  assign y7_n0_aggr = $signed(r_acc[3]);
  assign y4_n1_aggr = $signed(r_acc[4]);
  assign y5_n1_aggr = $signed(r_acc[5]);
  assign y6_n1_aggr = $signed(r_acc[6]);
  assign y7_n1_aggr = $signed(r_acc[7]);

  assign res0_n0 = r_res0_n0;
  assign res1_n0 = r_res1_n0;
  assign res0_n1 = r_res0_n1;
  assign res1_n1 = r_res1_n1;

endmodule
